spm_arbiter: RTL and testbench
==============================

// Module: spm_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one signed 8x8 serial-parallel multiplier between N requesters.
//  Captures the winner's operands, pulses the SPM start, and watches for done with a watchdog.
//  Returns the 16-bit signed product, tagged with the requester ID, over a valid/ready response port.
//  Sits between the requesting ALU lanes and the single SPM FSM instance.
// PARAMETERS
//  N        4   number of requesters (2..8); ID_W = $clog2(N)
//  DATA_W   8   operand width; product width is 2*DATA_W
//  TIMEOUT  32  max cycles in WAIT before abort (the SPM needs ~2*DATA_W cycles)
// PORTS
//  clk_i        in   1          clock, rising edge
//  rst_i        in   1          reset, asynchronous, active-high
//  req_i        in   N          per-requester request level
//  a_i          in   N*DATA_W   operand A, requester k at [k*DATA_W +: DATA_W]
//  b_i          in   N*DATA_W   operand B, same packing
//  gnt_o        out  N          one-hot grant, one-cycle pulse
//  spm_start_o  out  1          start pulse to the SPM
//  spm_a_o      out  DATA_W     latched operand A to the SPM
//  spm_b_o      out  DATA_W     latched operand B to the SPM
//  spm_done_i   in   1          SPM completion strobe
//  spm_prod_i   in   2*DATA_W   SPM product, valid when spm_done_i=1
//  rsp_valid_o  out  1          response valid
//  rsp_ready_i  in   1          response accepted
//  rsp_id_o     out  ID_W       requester index of the response
//  rsp_prod_o   out  2*DATA_W   signed product (0 when rsp_err_o=1)
//  rsp_err_o    out  1          watchdog abort flag
//  busy_o       out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE; rr_ptr=N-1 so requester 0 has first priority; all outputs 0; wd_cnt=0.
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered.
//  IDLE: if req_i!=0, pick the first set bit scanning rr_ptr+1, rr_ptr+2, ... (mod N).
//   - At the clock edge: latch operands into spm_a_o/spm_b_o, latch winner into rsp_id_o and rr_ptr,
//     set gnt_o[winner]=1, go to ISSUE. If req_i==0, stay in IDLE.
//  ISSUE (1 cycle): gnt_o one-hot and spm_start_o=1; next state WAIT, wd_cnt=0.
//   - Requester sees gnt_o and must drop req_i next cycle; req_i is ignored outside IDLE.
//  WAIT: gnt_o=0, spm_start_o=0; spm_a_o/spm_b_o held stable; wd_cnt increments each cycle.
//   - spm_done_i=1: latch spm_prod_i into rsp_prod_o, rsp_err_o=0, go to RESP.
//   - Else if wd_cnt==TIMEOUT-1: rsp_prod_o=0, rsp_err_o=1, go to RESP.
//   - If done arrives in the same cycle as the timeout, done wins (no error).
//  RESP: rsp_valid_o=1; rsp_id_o/rsp_prod_o/rsp_err_o held until rsp_valid_o&rsp_ready_i.
//   - Handshake cycle: clear rsp_valid_o, go to IDLE.
//   - A new grant is possible the cycle after returning to IDLE (no IDLE bypass).
//  spm_done_i outside WAIT is ignored. The product is passed through unmodified (already signed 2*DATA_W).
//  Latency: req seen at edge 0 -> gnt/start high in cycle 1 -> WAIT from cycle 2;
//   done in cycle k -> rsp_valid_o high from cycle k+1.
//  Fairness: after a grant to k, k has the lowest priority; persistent requesters are served strictly in rotation.
//  rst_i mid-operation returns to IDLE at once, drops all outputs, and loses the in-flight result.
// TESTING
//  Single req: req_i=0001, a=8'hFB(-5), b=8'h07; SPM model returns 0xFFDD
//   -> gnt_o=0001 one cycle, spm_start_o one pulse, rsp id=0, prod=16'hFFDD, err=0.
//  Corners: a=b=8'h80 -> prod 16'h4000; a=8'h80, b=8'h7F -> prod 16'hC080.
//  Round-robin: req_i=1111 held and re-raised after each grant -> grant order 0,1,2,3,0,1;
//   each rsp_id_o matches the granted index.
//  Backpressure: rsp_ready_i=0 for 10 cycles in RESP -> rsp_valid_o and data stable, no new gnt_o;
//   ready=1 -> IDLE next cycle.
//  Watchdog: SPM model never asserts done -> exactly TIMEOUT WAIT cycles, then rsp_err_o=1, prod=0;
//   done and timeout in the same cycle -> err=0.
//  Reset mid-WAIT: assert rst_i -> busy_o, rsp_valid_o, spm_start_o=0 immediately; the next request is granted to requester 0.

Source files
------------

// File: rtl/spm_arbiter.sv
// Round-robin arbiter and sequencer that shares one signed serial-parallel
// multiplier between N requesters. It grants one requester, hands the
// operands to the SPM with a start pulse, and waits for done under a watchdog.
// It then returns the product, tagged with the requester ID, over a
// valid/ready response port.
module spm_arbiter #(
  parameter int N       = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N-1:0]                 req_i,
  input  logic [N*DATA_W-1:0]          a_i,
  input  logic [N*DATA_W-1:0]          b_i,
  output logic [N-1:0]                 gnt_o,
  output logic                         spm_start_o,
  output logic [DATA_W-1:0]            spm_a_o,
  output logic [DATA_W-1:0]            spm_b_o,
  input  logic                         spm_done_i,
  input  logic [2*DATA_W-1:0]          spm_prod_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [$clog2(N)-1:0]         rsp_id_o,
  output logic [2*DATA_W-1:0]          rsp_prod_o,
  output logic                         rsp_err_o,
  output logic                         busy_o
);

  localparam int ID_W = $clog2(N);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [ID_W:0]   N_W     = (ID_W + 1)'(N);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
  logic [N-1:0]          gnt_q, gnt_d;
  logic                  start_q, start_d;
  logic [DATA_W-1:0]     spm_a_q, spm_a_d;
  logic [DATA_W-1:0]     spm_b_q, spm_b_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic [2*DATA_W-1:0]   rsp_prod_q, rsp_prod_d;
  logic                  rsp_err_q, rsp_err_d;

  // Unpacked view of the per-requester operand buses.
  logic [DATA_W-1:0]     a_arr [N];
  logic [DATA_W-1:0]     b_arr [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign a_arr[gi] = a_i[gi*DATA_W +: DATA_W];
      assign b_arr[gi] = b_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W:0]     cand;

  // Round-robin pick: scan from rr_ptr+1 upward (mod N). The scan runs from the
  // farthest offset down to the nearest, so the nearest requesting index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = N; off >= 1; off--) begin
      cand = {1'b0, rr_ptr_q} + (ID_W + 1)'(off);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (req_i[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Next-state and registered-output logic; everything holds unless a state acts.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    wd_cnt_d    = wd_cnt_q;
    gnt_d       = '0;
    start_d     = 1'b0;
    spm_a_d     = spm_a_q;
    spm_b_d     = spm_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_prod_d  = rsp_prod_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d        = S_ISSUE;
          gnt_d[win_idx] = 1'b1;
          start_d        = 1'b1;
          spm_a_d        = a_arr[win_idx];
          spm_b_d        = b_arr[win_idx];
          rsp_id_d       = win_idx;
          rr_ptr_d       = win_idx;
        end
      end
      S_ISSUE: begin
        state_d  = S_WAIT;
        wd_cnt_d = '0;
      end
      S_WAIT: begin
        // Done takes precedence over a coincident watchdog expiry.
        if (spm_done_i) begin
          state_d     = S_RESP;
          rsp_prod_d  = spm_prod_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d     = S_RESP;
          rsp_prod_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset gives requester 0 first priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= ID_W'(N - 1);
      wd_cnt_q    <= '0;
      gnt_q       <= '0;
      start_q     <= 1'b0;
      spm_a_q     <= '0;
      spm_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      wd_cnt_q    <= wd_cnt_d;
      gnt_q       <= gnt_d;
      start_q     <= start_d;
      spm_a_q     <= spm_a_d;
      spm_b_q     <= spm_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_prod_q  <= rsp_prod_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign spm_start_o = start_q;
  assign spm_a_o     = spm_a_q;
  assign spm_b_o     = spm_b_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_prod_o  = rsp_prod_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_spm_arbiter.sv
// Directed plus randomized bench for spm_arbiter. A small SPM model answers
// start pulses, and a round-robin reference model predicts grants and products.
module tb_spm_arbiter;

  localparam int N       = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 32;
  localparam int HANG    = 1000;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [N-1:0]         req_i;
  logic [N*DATA_W-1:0]  a_i;
  logic [N*DATA_W-1:0]  b_i;
  logic [N-1:0]         gnt_o;
  logic                 spm_start_o;
  logic [DATA_W-1:0]    spm_a_o;
  logic [DATA_W-1:0]    spm_b_o;
  logic                 spm_done_i;
  logic [2*DATA_W-1:0]  spm_prod_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [1:0]           rsp_id_o;
  logic [2*DATA_W-1:0]  rsp_prod_o;
  logic                 rsp_err_o;
  logic                 busy_o;

  int checks   = 0;
  int failures = 0;
  int model_ptr;
  logic [DATA_W-1:0] a_v [N];
  logic [DATA_W-1:0] b_v [N];

  spm_arbiter #(.N(N), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .gnt_o       (gnt_o),
    .spm_start_o (spm_start_o),
    .spm_a_o     (spm_a_o),
    .spm_b_o     (spm_b_o),
    .spm_done_i  (spm_done_i),
    .spm_prod_i  (spm_prod_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_prod_o  (rsp_prod_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Global time limit so the run always terminates.
  initial begin
    #2ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference round-robin: first requester after the last winner, modulo N.
  function automatic int model_pick(input logic [N-1:0] req);
    for (int off = 1; off <= N; off++) begin
      int k;
      k = (model_ptr + off) % N;
      if (req[k]) begin
        model_ptr = k;
        return k;
      end
    end
    return -1;
  endfunction

  function automatic logic [2*DATA_W-1:0] smul(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[2*DATA_W-1:0];
  endfunction

  task automatic pack_ops;
    for (int k = 0; k < N; k++) begin
      a_i[k*DATA_W +: DATA_W] = a_v[k];
      b_i[k*DATA_W +: DATA_W] = b_v[k];
    end
  endtask

  task automatic rand_ops;
    for (int k = 0; k < N; k++) begin
      a_v[k] = DATA_W'($urandom);
      b_v[k] = DATA_W'($urandom);
    end
    pack_ops();
  endtask

  // One full transaction: grant, SPM run (done after lat WAIT cycles, or never
  // when lat >= TIMEOUT), bp cycles of backpressure, then handshake.
  task automatic run_txn(input string name, input logic [N-1:0] req, input int lat, input int bp);
    int exp_id, exp_wait, w;
    bit seen, exp_err;
    logic [DATA_W-1:0] ea, eb;
    logic [2*DATA_W-1:0] eprod;
    exp_id   = model_pick(req);
    ea       = a_v[exp_id];
    eb       = b_v[exp_id];
    exp_err  = (lat >= TIMEOUT);
    eprod    = exp_err ? '0 : smul(ea, eb);
    exp_wait = exp_err ? TIMEOUT : lat + 1;

    req_i = req;
    tick();
    chk({name, "_gnt"}, 32'(gnt_o), 32'(1) << exp_id);
    chk({name, "_start"}, 32'(spm_start_o), 32'd1);
    chk({name, "_spm_a"}, 32'(spm_a_o), 32'(ea));
    chk({name, "_spm_b"}, 32'(spm_b_o), 32'(eb));
    chk({name, "_busy"}, 32'(busy_o), 32'd1);
    req_i = '0;
    tick();
    chk({name, "_gnt_drop"}, 32'(gnt_o), 32'd0);
    chk({name, "_start_drop"}, 32'(spm_start_o), 32'd0);

    seen = 1'b0;
    w    = 0;
    while (!seen && w < TIMEOUT + 4) begin
      if (w == exp_wait - 1) begin
        chk({name, "_spm_a_hold"}, 32'(spm_a_o), 32'(ea));
      end
      if (w == lat) begin
        spm_done_i = 1'b1;
        spm_prod_i = smul(spm_a_o, spm_b_o);
      end
      tick();
      spm_done_i = 1'b0;
      spm_prod_i = 16'($urandom);
      w++;
      if (rsp_valid_o) seen = 1'b1;
    end
    chk({name, "_rsp_seen"}, 32'(seen), 32'd1);
    chk({name, "_wait_cycles"}, 32'(w), 32'(exp_wait));
    chk({name, "_id"}, 32'(rsp_id_o), 32'(exp_id));
    chk({name, "_prod"}, 32'(rsp_prod_o), 32'(eprod));
    chk({name, "_err"}, 32'(rsp_err_o), 32'(exp_err));

    // Backpressure: response must hold, stray requests and done are ignored.
    for (int c = 0; c < bp; c++) begin
      req_i      = N'($urandom_range(1, (1 << N) - 1));
      spm_done_i = c[0];
      tick();
      chk({name, "_bp_valid"}, 32'(rsp_valid_o), 32'd1);
      chk({name, "_bp_prod"}, 32'(rsp_prod_o), 32'(eprod));
      chk({name, "_bp_id"}, 32'(rsp_id_o), 32'(exp_id));
      chk({name, "_bp_err"}, 32'(rsp_err_o), 32'(exp_err));
      chk({name, "_bp_gnt"}, 32'(gnt_o), 32'd0);
    end
    req_i       = '0;
    spm_done_i  = 1'b0;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk({name, "_hs_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({name, "_hs_busy"}, 32'(busy_o), 32'd0);
    $display("txn %s id=%0d a=%02h b=%02h wait=%0d prod=%04h err=%0b",
             name, rsp_id_o, ea, eb, w, rsp_prod_o, rsp_err_o);
  endtask

  initial begin
    rst_i       = 1'b1;
    req_i       = '0;
    a_i         = '0;
    b_i         = '0;
    spm_done_i  = 1'b0;
    spm_prod_i  = '0;
    rsp_ready_i = 1'b0;
    model_ptr   = N - 1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_start", 32'(spm_start_o), 32'd0);
    chk("rst_prod", 32'(rsp_prod_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Single request: -5 * 7 = 0xFFDD.
    rand_ops();
    a_v[0] = 8'hFB; b_v[0] = 8'h07; pack_ops();
    run_txn("single", 4'b0001, 14, 0);

    // Signed corners.
    a_v[0] = 8'h80; b_v[0] = 8'h80; pack_ops();
    run_txn("corner_80x80", 4'b0001, 15, 0);
    a_v[0] = 8'h80; b_v[0] = 8'h7F; pack_ops();
    run_txn("corner_80x7f", 4'b0001, 3, 0);

    // Reset in the middle of WAIT drops everything at once.
    rand_ops();
    req_i = 4'b0100;
    tick();
    chk("rstw_gnt", 32'(gnt_o), 32'(1) << model_pick(4'b0100));
    req_i = '0;
    repeat (3) tick();
    chk("rstw_busy_pre", 32'(busy_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("rstw_busy", 32'(busy_o), 32'd0);
    chk("rstw_valid", 32'(rsp_valid_o), 32'd0);
    chk("rstw_start", 32'(spm_start_o), 32'd0);
    chk("rstw_gnt0", 32'(gnt_o), 32'd0);
    tick();
    rst_i     = 1'b0;
    model_ptr = N - 1;
    tick();

    // Persistent requesters served in rotation, starting at requester 0.
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      run_txn($sformatf("rr%0d", i), 4'b1111, $urandom_range(0, 20), 0);
    end

    // Backpressure for 10 cycles.
    rand_ops();
    run_txn("backpressure", 4'b0010, 5, 10);

    // Watchdog: no done at all, then done coincident with the timeout.
    rand_ops();
    run_txn("watchdog", 4'b1000, HANG, 0);
    rand_ops();
    run_txn("done_at_timeout", 4'b0001, TIMEOUT - 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      rand_ops();
      run_txn($sformatf("rand%0d", i), N'($urandom_range(1, (1 << N) - 1)),
              $urandom_range(0, TIMEOUT + 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
